// File: rtl/vector_exec_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// vec_exec_pkg
// Shared types for the vector execution sequencer: the packed micro-op that
// travels from decode to the execution unit, op-code constants, the
// sequencer state enum and a helper that classifies multi-cycle ops.
// ---------------------------------------------------------------------------
package vec_exec_pkg;

    localparam int MAX_VLEN = 512;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SHIFT = 3'b001;
    localparam logic [2:0] OP_NOP   = 3'b010;
    localparam logic [2:0] OP_MUL   = 3'b011;
    localparam logic [2:0] OP_BIT   = 3'b100;
    localparam logic [2:0] OP_CMP   = 3'b101;
    localparam logic [2:0] OP_MOV   = 3'b110;
    localparam logic [2:0] OP_MAC   = 3'b111;

    typedef struct packed {
        logic [2:0] op;
        logic       ctrl;
        logic       signed_mode;
        logic       mul_low;
        logic       mul_high;
        logic       reverse_sub;
        logic [4:0] bitwise_op;
        logic [2:0] cmp_op;
        logic [2:0] accum_op;
        logic [2:0] shift_op;
        logic [6:0] sew_eew;
        logic [4:0] vd;
    } exec_uop_t;

    localparam int EXEC_UOP_W = $bits(exec_uop_t);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } seq_state_t;

    // Multiply and multiply-add are the only ops whose completion is signalled
    // by eu_done; everything else settles within one cycle.
    function automatic logic is_multicycle(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MAC);
    endfunction

endpackage

// File: rtl/vector_exec_sequencer_if.sv
// ---------------------------------------------------------------------------
// vector_exec_sequencer_if
// Bundles the three handshakes around the sequencer: decode issue
// (in_*), execution-unit drive/collect (eu_*) and writeback (wb_*), plus busy.
//   master : the sequencer's view (drives in_ready, eu_*, wb_*, busy)
//   slave  : the surrounding pipeline / execution unit view
// ---------------------------------------------------------------------------
interface vector_exec_sequencer_if #(
    parameter int VLEN = vec_exec_pkg::MAX_VLEN
) ();
    import vec_exec_pkg::*;

    logic            in_valid;
    logic            in_ready;
    exec_uop_t       in_uop;
    logic [VLEN-1:0] in_data_1;
    logic [VLEN-1:0] in_data_2;
    logic [VLEN-1:0] in_data_3;

    logic [VLEN-1:0] eu_data_1;
    logic [VLEN-1:0] eu_data_2;
    logic [VLEN-1:0] eu_data_3;
    exec_uop_t       eu_uop;
    logic [VLEN-1:0] eu_result;
    logic            eu_done;

    logic            wb_valid;
    logic            wb_ready;
    logic [VLEN-1:0] wb_result;
    logic [4:0]      wb_vd;
    logic            wb_err;

    logic            busy;

    modport master (
        input  in_valid, in_uop, in_data_1, in_data_2, in_data_3,
        input  eu_result, eu_done, wb_ready,
        output in_ready, eu_data_1, eu_data_2, eu_data_3, eu_uop,
        output wb_valid, wb_result, wb_vd, wb_err, busy
    );

    modport slave (
        output in_valid, in_uop, in_data_1, in_data_2, in_data_3,
        output eu_result, eu_done, wb_ready,
        input  in_ready, eu_data_1, eu_data_2, eu_data_3, eu_uop,
        input  wb_valid, wb_result, wb_vd, wb_err, busy
    );

endinterface

// File: rtl/vector_exec_sequencer_watchdog.sv
// ---------------------------------------------------------------------------
// vec_exec_watchdog
// Saturating cycle counter used to abort multi-cycle ops that never signal
// eu_done. Compiled only when VEC_EXEC_TIMEOUT_EN is defined.
//   clk, reset  : clock, synchronous active-high reset
//   i_clear     : restart the count at 0 (new op accepted)
//   i_enable    : count this cycle
//   o_expired   : count has reached TIMEOUT_CYCLES
// ---------------------------------------------------------------------------
`ifdef VEC_EXEC_TIMEOUT_EN
module vec_exec_watchdog
    import vec_exec_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != CNT_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count >= LIMIT);

endmodule
`endif

// File: rtl/vector_exec_sequencer.sv
// ---------------------------------------------------------------------------
// vector_exec_sequencer
// Accepts one decoded vector micro-op, holds its operands/controls stable on
// the execution unit until the result is ready, captures the result and
// offers it to writeback. One op outstanding at a time.
//   clk, reset : clock, synchronous active-high reset
//   bus        : vector_exec_sequencer_if.master (in_*, eu_*, wb_*, busy)
// Optional feature: define VEC_EXEC_TIMEOUT_EN to abort multi-cycle ops after
// TIMEOUT_CYCLES without eu_done (result 0, wb_err=1).
// ---------------------------------------------------------------------------
module vector_exec_sequencer
    import vec_exec_pkg::*;
#(
    parameter int VLEN           = MAX_VLEN,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    vector_exec_sequencer_if.master   bus
);

    // NOP op code keeps every functional unit disabled while no op is active.
    localparam exec_uop_t UOP_IDLE = '{op: OP_NOP, default: '0};

    seq_state_t      r_state;
    exec_uop_t       r_uop;
    logic [VLEN-1:0] r_data1;
    logic [VLEN-1:0] r_data2;
    logic [VLEN-1:0] r_data3;
    logic [VLEN-1:0] r_result;
    logic [4:0]      r_vd;
    logic            r_err;
    logic            r_firstExec;

    logic            w_accept;
    logic            w_timeout;
    logic            w_execDone;
    logic            w_execErr;
    logic [VLEN-1:0] w_execResult;

    assign w_accept = (r_state == IDLE) && bus.in_valid && !reset;

`ifdef VEC_EXEC_TIMEOUT_EN
    vec_exec_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_accept),
        .i_enable  (r_state == EXEC),
        .o_expired (w_timeout)
    );
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
`endif

    // Decide whether the op in EXEC finishes this cycle and what it leaves
    // behind. Multi-cycle ops ignore eu_done in their first cycle because the
    // unit has only just seen the operands; eu_done wins over a timeout that
    // lands in the same cycle.
    always_comb begin
        w_execDone   = 1'b0;
        w_execErr    = 1'b0;
        w_execResult = '0;
        if (r_state == EXEC) begin
            if (!is_multicycle(r_uop.op)) begin
                w_execDone   = 1'b1;
                w_execResult = (r_uop.op == OP_NOP) ? '0 : bus.eu_result;
            end else if (!r_firstExec) begin
                if (bus.eu_done) begin
                    w_execDone   = 1'b1;
                    w_execResult = bus.eu_result;
                end else if (w_timeout) begin
                    w_execDone = 1'b1;
                    w_execErr  = 1'b1;
                end
            end
        end
    end

    // Operand regs are cleared when EXEC ends so the execution unit sees
    // zeros and the NOP code in RESP and IDLE without an extra output mux.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_uop       <= UOP_IDLE;
            r_data1     <= '0;
            r_data2     <= '0;
            r_data3     <= '0;
            r_result    <= '0;
            r_vd        <= '0;
            r_err       <= 1'b0;
            r_firstExec <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_uop       <= bus.in_uop;
                        r_data1     <= bus.in_data_1;
                        r_data2     <= bus.in_data_2;
                        r_data3     <= bus.in_data_3;
                        r_firstExec <= 1'b1;
                        r_state     <= EXEC;
                    end
                end
                EXEC: begin
                    r_firstExec <= 1'b0;
                    if (w_execDone) begin
                        r_result <= w_execResult;
                        r_err    <= w_execErr;
                        r_vd     <= r_uop.vd;
                        r_uop    <= UOP_IDLE;
                        r_data1  <= '0;
                        r_data2  <= '0;
                        r_data3  <= '0;
                        r_state  <= RESP;
                    end
                end
                RESP: begin
                    if (bus.wb_ready) begin
                        r_err   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE) && !reset;
    assign bus.busy      = (r_state != IDLE);
    assign bus.eu_uop    = r_uop;
    assign bus.eu_data_1 = r_data1;
    assign bus.eu_data_2 = r_data2;
    assign bus.eu_data_3 = r_data3;
    assign bus.wb_valid  = (r_state == RESP);
    assign bus.wb_result = r_result;
    assign bus.wb_vd     = r_vd;
    assign bus.wb_err    = r_err;

endmodule

// File: doc/vector_exec_sequencer.md
# vector_exec_sequencer

Issue/collect sequencer that drives the vector execution unit from the decode side and returns its results to writeback. It accepts one decoded micro-op with its operands over a valid/ready handshake. It then holds operands and controls stable on the execution unit for as long as the operation needs, captures the result on completion, and presents it to the register-file writeback stage over a second valid/ready handshake. It sits between vector decode/operand read and writeback, and wraps the execution unit's combinational and multi-cycle paths in one uniform handshake.

## Interface
- VLEN, default 512 (`MAX_VLEN`): operand and result width.
- TIMEOUT_CYCLES, default 64: watchdog limit for multi-cycle ops (used only when the watchdog is compiled in).
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- in_valid  in  1  decode offers a micro-op.
- in_ready  out  1  sequencer accepts; high only in IDLE.
- in_uop  in  EXEC_UOP_W  packed exec_uop_t: op[2:0], ctrl, signed_mode, mul_low, mul_high, reverse_sub, bitwise_op[4:0], cmp_op[2:0], accum_op[2:0], shift_op[2:0], sew_eew[6:0], vd[4:0].
- in_data_1/2/3  in  VLEN  source operands.
- eu_data_1/2/3  out  VLEN  operands driven to the execution unit.
- eu_uop  out  EXEC_UOP_W  control fields driven to the execution unit.
- eu_result  in  VLEN  execution unit result.
- eu_done  in  1  execution unit completion flag.
- wb_valid  out  1  result available.
- wb_ready  in  1  writeback accepts.
- wb_result  out  VLEN  captured result.
- wb_vd  out  5  destination register.
- wb_err  out  1  result was produced by a watchdog timeout.
- busy  out  1  high in every state except IDLE.

## Operation
- **FSM states:** IDLE, EXEC, RESP.
- **IDLE:**
  - in_ready=1.
  - eu_data_* = 0 and eu_uop.op = 3'b010 (the unused encoding, so all units are disabled).
  - On in_valid&&in_ready: register in_uop and in_data_* into the operand regs, clear the cycle counter, go to EXEC.
- **EXEC:** operand regs are driven onto eu_*, unchanged for the whole state.
  - Fixed-latency ops (000 add/rsub, 001 shift, 100 bitwise, 101 compare, 110 move): capture eu_result into the result reg at the end of the first EXEC cycle, then go to RESP. eu_done is ignored.
  - NOP op 010: capture 0, then go to RESP after one EXEC cycle.
  - Multi-cycle ops (011 multiply, 111 multiply-add):
    - eu_done is ignored in the first EXEC cycle.
    - From the second cycle on, eu_done=1 captures eu_result and the FSM goes to RESP.
    - Otherwise the FSM stays in EXEC and the counter increments, saturating at its maximum.
- **RESP:**
  - wb_valid=1; wb_result, wb_vd and wb_err are held stable.
  - On wb_ready: go to IDLE, wb_valid drops the next cycle.
  - No new op is accepted until IDLE (single outstanding op).
- **Reset mid-operation:** abandon the op and go to IDLE. All outputs take their reset values, and the result reg and operand regs clear to 0.
- **Reset values:** in_ready=0 in the reset cycle and 1 afterwards in IDLE. wb_valid=0, wb_result=0, wb_vd=0, wb_err=0, busy=0, eu_data_*=0, eu_uop=0 except op=3'b010.

## Timing
- Handshake at cycle T: eu_* driven from T+1.
- Fixed op: result captured at the end of T+1, wb_valid=1 at T+2.
- Multi-cycle op, with eu_done first seen high at T+k (k≥2): wb_valid=1 at T+k+1.
- wb_ready already high when wb_valid rises: one RESP cycle, IDLE at the next cycle.
- Back-to-back throughput: one op per 3 cycles minimum.
- in_valid while busy: ignored. Decode must hold the op until in_ready.

## Configuration
- Macro: `VEC_EXEC_TIMEOUT_EN`.
- **Defined:**
  - In EXEC for a multi-cycle op, if the counter reaches TIMEOUT_CYCLES with eu_done still low, capture result 0, set wb_err=1, and go to RESP.
  - wb_err clears when the FSM next leaves RESP.
- **Undefined:** EXEC waits indefinitely for eu_done; wb_err is tied to 0 and TIMEOUT_CYCLES is unused.

## Structure
- Package vec_exec_pkg holds:
  - exec_uop_t and EXEC_UOP_W;
  - op-code localparams OP_ADD=3'b000, OP_SHIFT=001, OP_NOP=010, OP_MUL=011, OP_BIT=100, OP_CMP=101, OP_MOV=110, OP_MAC=111;
  - the state enum;
  - function is_multicycle(op).
- One sub-module, vec_exec_watchdog: cycle counter with clear/enable inputs, compiled only under `VEC_EXEC_TIMEOUT_EN`.

## Test plan
- **Add:** add op, sew_eew=7'b0001000, data_1 lanes=8'h05, data_2 lanes=8'h03, eu_result stub=all 8'h08, wb_ready=1 → wb_valid at T+2, wb_result=all 8'h08, wb_vd echoed.
- **Multiply:** multiply op with the eu_done stub at T+5 → eu_data_* stable T+1..T+5, wb_valid at T+6, wb_err=0.
- **Backpressure:** wb_ready low for 4 cycles → wb_valid/wb_result held; in_ready=0 throughout; IDLE one cycle after wb_ready.
- **Reset mid-op:** reset asserted during EXEC of a multiply → next cycle IDLE, wb_valid=0, eu_data_*=0, eu_uop.op=010.
- **Timeout (`VEC_EXEC_TIMEOUT_EN`, TIMEOUT_CYCLES=8):** eu_done never asserted → wb_valid with wb_result=0, wb_err=1; the following add returns wb_err=0.
- **NOP and ignored input:** op 010 → wb_result=0 at T+2; a second in_valid while busy is not accepted (in_ready=0).
